// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings, counter
// direction and the saturating duty compare used by every channel.
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Duty values at or above 2^n clamp to constant high, so an
    // over-range duty never wraps into a short pulse.
    function automatic logic pwm_duty_hit(
        input logic [31:0] cnt,
        input logic [31:0] duty,
        input int unsigned n
    );
        logic [31:0] full;
        full = 32'd1 << n;
        if (duty >= full) begin
            return 1'b1;
        end
        return (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter, period-start detect
// and the active counting mode latched at each period boundary.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int N       = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               mode_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic [N-1:0]       cnt_next_o,
    output logic               tick_o,
    output logic               period_start_o,
    output logic               load_o
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [N-1:0]       cnt_q, cnt_d;
    pwm_dir_e           dir_q, dir_d;
    logic               mode_q, mode_d;
    logic               run_q;
    logic               tick;
    logic               period_start;
    logic               restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            mode_q  <= PWM_MODE_EDGE;
            run_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            run_q   <= en_i;
        end
    end

    // The first enabled edge re-enters counter 0 like a period start but
    // without the tick pulse, so the first period is a full one.
    always_comb begin
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        mode_d       = mode_q;
        tick         = 1'b0;
        period_start = 1'b0;
        restart      = 1'b0;
        if (!en_i) begin
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = DIR_UP;
            mode_d  = mode_i;
        end else if (!run_q) begin
            restart = 1'b1;
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = DIR_UP;
            mode_d  = mode_i;
        end else begin
            tick    = (presc_q >= prescale_i);
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
                if (mode_q == PWM_MODE_EDGE) begin
                    cnt_d        = cnt_q + N'(1);
                    dir_d        = DIR_UP;
                    period_start = (cnt_q == CNT_MAX);
                end else if (dir_q == DIR_UP) begin
                    // Top of the triangle is held for one extra tick.
                    if (cnt_q == CNT_MAX) begin
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + N'(1);
                    end
                end else begin
                    if (cnt_q == '0) begin
                        dir_d        = DIR_UP;
                        period_start = 1'b1;
                    end else begin
                        cnt_d = cnt_q - N'(1);
                    end
                end
                if (period_start) begin
                    mode_d = mode_i;
                end
            end
        end
    end

    assign cnt_next_o     = cnt_d;
    assign tick_o         = tick;
    assign period_start_o = period_start;
    assign load_o         = !en_i || restart || period_start;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared timebase driving CHANNELS shadow/active
// duty register pairs and registered compare outputs.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int N        = 8,
    parameter int PRESC_W  = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                mode_in,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                duty_wr,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [N:0]          duty_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [N-1:0] cnt_next;
    logic         tick;
    logic         period_start;
    logic         load;
    logic         period_tick_q;

    pwm_timebase #(
        .N       (N),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk            (clk),
        .reset          (reset),
        .en_i           (en),
        .mode_i         (mode_in),
        .prescale_i     (prescale),
        .cnt_next_o     (cnt_next),
        .tick_o         (tick),
        .period_start_o (period_start),
        .load_o         (load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_tick_q <= 1'b0;
        end else begin
            period_tick_q <= period_start;
        end
    end

    assign period_tick = period_tick_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [N:0] shadow_q, shadow_d;
            logic [N:0] active_q, active_d;
            logic       pwm_q, pwm_d;
            logic       wr_hit;

            assign wr_hit   = duty_wr && (duty_ch == CH_W'(gi));
            assign shadow_d = wr_hit ? duty_data : shadow_q;
            // Active copies the pre-write shadow, so a write landing on the
            // boundary edge waits one more period.
            assign active_d = load ? shadow_q : active_q;
            // Compare against the duty that will be active after this edge
            // so the first sample of a new period already uses the new duty.
            assign pwm_d    = en && pwm_duty_hit(32'(cnt_next), 32'(active_d), N);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    shadow_q <= '0;
                    active_q <= '0;
                    pwm_q    <= 1'b0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                    if (tick || load) begin
                        pwm_q <= pwm_d;
                    end
                end
            end

            assign pwm_out[gi] = pwm_q;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected per-period lengths and high counts
// are queued by the stimulus and checked by a monitor at each period_tick.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int N  = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          mode_in;
    logic [PW-1:0] prescale;
    logic          duty_wr;
    logic [1:0]    duty_ch;
    logic [N:0]    duty_data;
    logic [CH-1:0] pwm_out;
    logic          period_tick;

    always #5 clk = ~clk;

    pwm_multi #(
        .CHANNELS (CH),
        .N        (N),
        .PRESC_W  (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode_in     (mode_in),
        .prescale    (prescale),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_data   (duty_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    typedef struct {
        string tag;
        int    len;
        int    hi[CH];
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_hold = 1'b1;

    function automatic void check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endfunction

    function automatic void expect_period(input string tag, input int len,
                                          input int h0, input int h1,
                                          input int h2, input int h3);
        exp_t e;
        e.tag   = tag;
        e.len   = len;
        e.hi[0] = h0;
        e.hi[1] = h1;
        e.hi[2] = h2;
        e.hi[3] = h3;
        exp_q.push_back(e);
    endfunction

    // Monitor: a period runs from one period_tick sample to the next.
    initial begin
        bit   armed;
        int   len_acc;
        int   hi_acc[CH];
        exp_t e;
        armed = 1'b0;
        len_acc = 0;
        for (int c = 0; c < CH; c++) hi_acc[c] = 0;
        forever begin
            @(negedge clk);
            if (reset || mon_hold) begin
                armed = 1'b0;
            end else if (period_tick) begin
                if (armed && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("[TB] period %s: len %0d, high %0d %0d %0d %0d",
                             e.tag, len_acc, hi_acc[0], hi_acc[1], hi_acc[2], hi_acc[3]);
                    check({e.tag, "_len"}, len_acc, e.len);
                    for (int c = 0; c < CH; c++)
                        check($sformatf("%s_hi%0d", e.tag, c), hi_acc[c], e.hi[c]);
                end
                armed   = 1'b1;
                len_acc = 1;
                for (int c = 0; c < CH; c++) hi_acc[c] = int'(pwm_out[c]);
            end else if (armed) begin
                len_acc++;
                for (int c = 0; c < CH; c++) hi_acc[c] += int'(pwm_out[c]);
            end
        end
    end

    task automatic wr(input int ch, input int val);
        duty_wr   = 1'b1;
        duty_ch   = ch[1:0];
        duty_data = val[N:0];
        @(negedge clk);
        duty_wr   = 1'b0;
    endtask

    task automatic wait_tick(input string name, input int bound);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!period_tick && w < bound);
        check({name, "_tick_seen"}, int'(period_tick), 1);
    endtask

    // Counts negedges from the first one after the restart edge (already
    // consumed by the caller) up to the one showing period_tick.
    task automatic count_to_tick(input string name, input int want, input int bound);
        int w;
        w = 1;
        while (!period_tick && w < bound) begin
            @(negedge clk);
            w++;
        end
        check(name, w, want);
    endtask

    task automatic drain(input string name, input int bound);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < bound) begin
            @(negedge clk);
            w++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        mode_in   = 1'b0;
        prescale  = '0;
        duty_wr   = 1'b0;
        duty_ch   = '0;
        duty_data = '0;

        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_tick", int'(period_tick), 0);
        reset = 1'b0;

        // Edge mode: ch0=64, ch1=0, ch2=256 and ch3=300 saturate high.
        wr(0, 64);
        wr(1, 0);
        wr(2, 256);
        wr(3, 300);
        expect_period("edge_a", 256, 64, 0, 256, 256);
        expect_period("edge_b", 256, 64, 0, 256, 256);
        en       = 1'b1;
        mon_hold = 1'b0;
        @(negedge clk);
        check("enable_first_out", int'(pwm_out), 13);
        check("enable_first_tick", int'(period_tick), 0);
        count_to_tick("enable_first_period", 257, 3000);
        drain("edge", 2000);

        // Shadow update: mid-period write, then a write on the boundary edge.
        wait_tick("shadow_sync", 2000);
        @(negedge clk);
        expect_period("shadow_cur", 256, 64, 0, 256, 256);
        expect_period("shadow_next", 256, 128, 0, 256, 256);
        expect_period("shadow_edge_wr", 256, 128, 0, 256, 256);
        expect_period("shadow_after", 256, 32, 0, 256, 256);
        repeat (99) @(negedge clk);
        wr(0, 128);
        repeat (410) @(negedge clk);
        wr(0, 32);
        drain("shadow", 2000);

        // Center mode switch mid-period, then back to edge mid-period.
        wait_tick("center_sync", 2000);
        @(negedge clk);
        expect_period("center_pre", 256, 32, 0, 256, 256);
        expect_period("center_a", 512, 128, 0, 512, 512);
        expect_period("center_b", 512, 128, 0, 512, 512);
        expect_period("center_back", 256, 64, 0, 256, 256);
        repeat (49) @(negedge clk);
        mode_in = 1'b1;
        wr(0, 64);
        repeat (949) @(negedge clk);
        mode_in = 1'b0;
        drain("center", 3000);

        // Enable low mid-period, then prescale 3 from a fresh start.
        mon_hold = 1'b1;
        repeat (30) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_low_out", int'(pwm_out), 0);
        begin
            int bad;
            bad = 0;
            repeat (300) begin
                @(negedge clk);
                if (period_tick || pwm_out != '0) bad++;
            end
            check("en_low_hold", bad, 0);
        end
        prescale = 8'd3;
        wr(0, 128);
        expect_period("presc_a", 1024, 512, 0, 1024, 1024);
        expect_period("presc_b", 1024, 512, 0, 1024, 1024);
        en       = 1'b1;
        mon_hold = 1'b0;
        @(negedge clk);
        check("presc_first_out", int'(pwm_out), 13);
        count_to_tick("presc_first_period", 1025, 5000);
        drain("presc", 5000);

        // Asynchronous reset while period_tick and outputs are high.
        wait_tick("reset_sync", 5000);
        mon_hold = 1'b1;
        check("pre_reset_out", int'(pwm_out), 13);
        #1 reset = 1'b1;
        #1;
        check("async_reset_pwm", int'(pwm_out), 0);
        check("async_reset_tick", int'(period_tick), 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_out", int'(pwm_out), 0);
        count_to_tick("post_reset_period", 1025, 5000);
        check("post_reset_shadow_lost", int'(pwm_out), 0);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator that extends the single-channel, fixed-mode PWM block. It has per-channel duty registers with period-boundary (shadow) update, a programmable clock prescaler, and selectable edge-aligned or center-aligned counting. It sits between a register/control interface and the pad-level PWM outputs (motor, LED, DAC-filter drives). All channels share one timebase, so their periods are phase-locked.

## Interface
- `CHANNELS`, default 4: number of PWM outputs, ≥1.
- `N`, default 8: counter resolution in bits; one edge-aligned period is 2^N ticks.
- `PRESC_W`, default 8: prescaler width.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `en` in 1: timebase run enable.
- `mode_in` in 1: 0 = edge-aligned, 1 = center-aligned.
- `prescale` in PRESC_W: one tick every `prescale`+1 clk cycles.
- `duty_wr` in 1: one-cycle write strobe for the shadow duty.
- `duty_ch` in $clog2(CHANNELS) (min 1): target channel. Writes with `duty_ch` ≥ CHANNELS are ignored.
- `duty_data` in N+1: duty value; the extra bit allows 100%.
- `pwm_out` out CHANNELS: registered PWM outputs.
- `period_tick` out 1: one-clk pulse at each period start.

## Operation
- **Reset values:**
  - `pwm_out`=0, `period_tick`=0.
  - counter=0, direction=up, prescaler=0.
  - shadow and active duty=0, active mode=edge.
- **Prescaler:**
  - Counts 0..`prescale`; `tick` is asserted in the cycle it equals `prescale`, then it returns to 0.
  - `prescale` is sampled live.
- **Edge mode:**
  - Counter runs 0..2^N−1 and wraps to 0 on a tick.
- **Center mode:**
  - Counter runs up 0..2^N−1, holds 2^N−1 for one extra tick while direction flips, counts down to 0, holds 0 one extra tick, then flips to up.
  - One period = 2^(N+1) ticks.
- **Period start:**
  - Edge mode: the tick at which the counter enters 0 by wrap.
  - Center mode: the tick at which direction flips down→up.
  - On the same edge:
    - all active duties ← shadow duties;
    - active mode ← `mode_in`;
    - `period_tick` pulses on the next cycle.
- **Output rule:**
  - `pwm_out[i]` = (next counter < active duty[i]), registered on the same edge the counter updates.
  - Duty 0 → constant low.
  - Duty ≥ 2^N → constant high (saturating compare, no wrap).
  - Duty cycle = min(duty, 2^N)/2^N in both modes.
- **Writes:**
  - `duty_wr` loads `shadow[duty_ch]` ← `duty_data` at any time.
  - A write coinciding with a period-start edge goes to the shadow only; the active register loads the pre-write shadow value.
- **`en`=0:**
  - prescaler, counter and direction are held at reset values;
  - `pwm_out`=0, no `period_tick`;
  - active duties and active mode track shadow and `mode_in` every cycle.
- **`en` 0→1:** the first period starts from counter 0 with no period-start pulse for that edge.
- **Mid-operation `reset`:** all state clears immediately, with no wait for a clock edge. Shadow duties are lost.

## Timing
- `pwm_out` latency: 1 clk from the counter state it is derived from. There is no extra pipeline.
- A duty write at cycle t becomes visible at the first period start after t+1.
- A mode change becomes visible at the next period start only.
- `period_tick` is 1 clk wide and is asserted the cycle after the counter reaches the start value.
- Period length:
  - edge mode: (`prescale`+1)·2^N clk;
  - center mode: (`prescale`+1)·2^(N+1) clk.

## Structure
- **Package `pwm_pkg`:**
  - mode encoding constants `PWM_MODE_EDGE`=0 and `PWM_MODE_CENTER`=1;
  - the saturating-compare helper function.
- **Sub-module `pwm_timebase`:**
  - contains the prescaler, counter, direction, period-start detect and active mode;
  - outputs the next counter value, tick and period start.
- **Top level:** a generate loop of CHANNELS shadow/active duty registers and output compare flops.

## Test plan
(N=8, CHANNELS=4, `prescale`=0 unless stated.)
- **Reset:** assert `reset` mid-cycle with outputs high → `pwm_out`=0000 and `period_tick`=0 at once, without waiting for a clock edge. After release with `en`=1, the counter restarts at 0.
- **Edge mode, ch0:** duty=64 → `pwm_out[0]` high for 64 of every 256 clk. `period_tick` is spaced 256 clk apart. Other channels (duty 0) stay low.
- **Saturation and zero:**
  - duty=0 → always low;
  - duty=256 → always high;
  - duty=300 → always high, with no glitch at wrap.
- **Shadow update:** active=64; write duty=128 when the counter is 100 → the current period is still 64 high, the next period is 128 high. A write on the period-start edge applies one period later.
- **Center mode:** `mode_in`=1 with duty=64 → period 512 clk, high 128 clk split 64+64 symmetric around counter 0. A mode switch mid-period takes effect only at the next period start.
- **Prescale and enable:**
  - `prescale`=3, duty=128 → period 1024 clk, high 512 clk.
  - `en`=0 mid-period → outputs drop low and the counter holds 0.
  - `en`=1 → restart from 0 with the current shadow duties.
